// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: decode inputs and control strobes between controller and datapath
// master: controller side (receives instruction fields/flags, drives control)
// slave : datapath side (drives instruction fields/flags, receives control)
interface multicycle_controller_if;
  logic [6:0] op_6_0;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero_flag;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_req;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic       reg_write;
  logic [2:0] alu_control;
  logic       illegal_instr;
  logic       instr_done;
  modport master (
    input  op_6_0, funct3, funct7_5, zero_flag, mem_ready,
    output pc_write, adr_src, mem_req, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, imm_src, reg_write, alu_control,
           illegal_instr, instr_done
  );
  modport slave (
    output op_6_0, funct3, funct7_5, zero_flag, mem_ready,
    input  pc_write, adr_src, mem_req, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, imm_src, reg_write, alu_control,
           illegal_instr, instr_done
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RISC-V control FSM (load/store/R/I/beq/jal)
// clk   : sole clock, rising edge
// rst_n : asynchronous active-low reset, forces FETCH
// ctl   : master side of multicycle_controller_if (decode inputs in, control strobes out)
module multicycle_controller (
  input logic clk,
  input logic rst_n,
  multicycle_controller_if.master ctl
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;
  state_t state, next;
  logic [2:0] alu_op;
  logic       is_store;
  assign is_store = ctl.op_6_0[5];
  // sub only for R-type (op bit 5 set); addi with instr[30]=1 stays add
  assign alu_op = ctl.funct3 == 3'b000 ? ((ctl.op_6_0[5] & ctl.funct7_5) ? 3'b001 : 3'b000) :
                  ctl.funct3 == 3'b010 ? 3'b101 :
                  ctl.funct3 == 3'b110 ? 3'b011 :
                  ctl.funct3 == 3'b111 ? 3'b010 : 3'b000;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= next;
  always_comb begin
    next              = state;
    ctl.pc_write      = 1'b0;
    ctl.adr_src       = 1'b0;
    ctl.mem_req       = 1'b0;
    ctl.mem_write     = 1'b0;
    ctl.ir_write      = 1'b0;
    ctl.result_src    = 2'b00;
    ctl.alu_src_a     = 2'b00;
    ctl.alu_src_b     = 2'b00;
    ctl.imm_src       = 2'b00;
    ctl.reg_write     = 1'b0;
    ctl.alu_control   = 3'b000;
    ctl.illegal_instr = 1'b0;
    ctl.instr_done    = 1'b0;
    case (state)
      FETCH: begin
        ctl.mem_req    = 1'b1;
        ctl.alu_src_b  = 2'b10;
        ctl.result_src = 2'b10;
        // held in reset the fetch must not load PC/IR even if memory answers
        ctl.ir_write   = ctl.mem_ready & rst_n;
        ctl.pc_write   = ctl.mem_ready & rst_n;
        next           = ctl.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ctl.alu_src_a = 2'b01;
        ctl.alu_src_b = 2'b01;
        ctl.imm_src   = 2'b10;
        case (ctl.op_6_0)
          7'b0000011, 7'b0100011: next = MEMADR;
          7'b0110011:             next = EXECUTER;
          7'b0010011:             next = EXECUTEI;
          7'b1100011:             next = BEQ;
          7'b1101111:             next = JAL;
          default: begin
            next              = FETCH;
            ctl.illegal_instr = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ctl.alu_src_a = 2'b10;
        ctl.alu_src_b = 2'b01;
        ctl.imm_src   = is_store ? 2'b01 : 2'b00;
        next          = is_store ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        ctl.mem_req = 1'b1;
        ctl.adr_src = 1'b1;
        next        = ctl.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ctl.result_src = 2'b01;
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        next           = FETCH;
      end
      MEMWRITE: begin
        ctl.mem_req    = 1'b1;
        ctl.mem_write  = 1'b1;
        ctl.adr_src    = 1'b1;
        ctl.instr_done = ctl.mem_ready;
        next           = ctl.mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ctl.alu_src_a   = 2'b10;
        ctl.alu_control = alu_op;
        next            = ALUWB;
      end
      EXECUTEI: begin
        ctl.alu_src_a   = 2'b10;
        ctl.alu_src_b   = 2'b01;
        ctl.alu_control = alu_op;
        next            = ALUWB;
      end
      ALUWB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        next           = FETCH;
      end
      BEQ: begin
        ctl.alu_src_a   = 2'b10;
        ctl.alu_control = 3'b001;
        ctl.pc_write    = ctl.zero_flag;
        ctl.instr_done  = 1'b1;
        next            = FETCH;
      end
      JAL: begin
        ctl.alu_src_a = 2'b01;
        ctl.alu_src_b = 2'b10;
        ctl.pc_write  = 1'b1;
        next          = ALUWB;
      end
      default: next = FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle scoreboard bench for multicycle_controller
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst_n;
  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .rst_n(rst_n), .ctl(bus.master));
  always #5 clk = ~clk;
  typedef struct {
    logic [18:0] v;
    string name;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  logic [18:0] act;
  assign act = {bus.pc_write, bus.adr_src, bus.mem_req, bus.mem_write, bus.ir_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
                bus.reg_write, bus.alu_control, bus.illegal_instr, bus.instr_done};
  function automatic logic [18:0] v(logic pcw, logic adr, logic mreq, logic mw, logic irw,
                                    logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                    logic [1:0] imm, logic rw, logic [2:0] alu,
                                    logic ill, logic done);
    return {pcw, adr, mreq, mw, irw, rs, sa, sb, imm, rw, alu, ill, done};
  endfunction
  function automatic logic [18:0] e_rst();
    return v(0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [18:0] e_fetch(logic r);
    return v(r, 0, 1, 0, r, 2'b10, 2'b00, 2'b10, 2'b00, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [18:0] e_decode(logic ill);
    return v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b10, 0, 3'b000, ill, 0);
  endfunction
  function automatic logic [18:0] e_memadr(logic st);
    return v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, st ? 2'b01 : 2'b00, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [18:0] e_memread();
    return v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0, 0);
  endfunction
  function automatic logic [18:0] e_memwb();
    return v(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0, 1);
  endfunction
  function automatic logic [18:0] e_memwrite(logic r);
    return v(0, 1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0, r);
  endfunction
  function automatic logic [18:0] e_execr(logic [2:0] alu);
    return v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, alu, 0, 0);
  endfunction
  function automatic logic [18:0] e_execi(logic [2:0] alu);
    return v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, alu, 0, 0);
  endfunction
  function automatic logic [18:0] e_aluwb();
    return v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0, 1);
  endfunction
  function automatic logic [18:0] e_beq(logic z);
    return v(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 0, 3'b001, 0, 1);
  endfunction
  function automatic logic [18:0] e_jal();
    return v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 3'b000, 0, 0);
  endfunction
  // one clock cycle: drive inputs just after the edge, queue what that cycle must show
  task automatic cyc(input logic rst, input logic ready, input logic zero,
                     input logic [18:0] e, input string name);
    rst_n         = rst;
    bus.mem_ready = ready;
    bus.zero_flag = zero;
    q.push_back('{e, name});
    @(posedge clk);
    #1;
  endtask
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    bus.op_6_0   = op;
    bus.funct3   = f3;
    bus.funct7_5 = f7;
  endtask
  task automatic alu_r(input logic [2:0] f3, input logic f7, input logic [2:0] alu, input string name);
    instr(7'b0110011, f3, f7);
    cyc(1, 1, 0, e_fetch(1), {name, "_fetch"});
    cyc(1, 1, 0, e_decode(0), {name, "_decode"});
    cyc(1, 1, 0, e_execr(alu), {name, "_exec"});
    cyc(1, 1, 0, e_aluwb(), {name, "_wb"});
  endtask
  task automatic alu_i(input logic [2:0] f3, input logic f7, input logic [2:0] alu, input string name);
    instr(7'b0010011, f3, f7);
    cyc(1, 1, 0, e_fetch(1), {name, "_fetch"});
    cyc(1, 1, 0, e_decode(0), {name, "_decode"});
    cyc(1, 1, 0, e_execi(alu), {name, "_exec"});
    cyc(1, 1, 0, e_aluwb(), {name, "_wb"});
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (act !== e.v) begin
        fails++;
        $display("FAIL %s got %b expected %b", e.name, act, e.v);
      end
    end
  initial begin
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    bus.zero_flag = 1'b0;
    instr(7'b0000011, 3'b010, 1'b0);
    @(posedge clk);
    #1;
    cyc(0, 1, 0, e_rst(), "reset_hold");
    cyc(1, 1, 0, e_fetch(1), "ld_fetch");
    cyc(1, 1, 0, e_decode(0), "ld_decode");
    cyc(1, 1, 0, e_memadr(0), "ld_memadr");
    cyc(1, 1, 0, e_memread(), "ld_memread");
    cyc(1, 1, 0, e_memwb(), "ld_memwb");
    instr(7'b0100011, 3'b010, 1'b0);
    cyc(1, 1, 0, e_fetch(1), "st_fetch");
    cyc(1, 1, 0, e_decode(0), "st_decode");
    cyc(1, 1, 0, e_memadr(1), "st_memadr");
    cyc(1, 0, 0, e_memwrite(0), "st_wait1");
    cyc(1, 0, 0, e_memwrite(0), "st_wait2");
    cyc(1, 1, 0, e_memwrite(1), "st_done");
    alu_r(3'b000, 1'b1, 3'b001, "r_sub");
    alu_r(3'b000, 1'b0, 3'b000, "r_add");
    alu_r(3'b010, 1'b0, 3'b101, "r_slt");
    alu_r(3'b110, 1'b0, 3'b011, "r_or");
    alu_r(3'b111, 1'b0, 3'b010, "r_and");
    alu_r(3'b001, 1'b1, 3'b000, "r_other");
    alu_i(3'b000, 1'b1, 3'b000, "i_addi_f7");
    alu_i(3'b110, 1'b0, 3'b011, "i_ori");
    instr(7'b1100011, 3'b000, 1'b0);
    cyc(1, 1, 0, e_fetch(1), "beq1_fetch");
    cyc(1, 1, 0, e_decode(0), "beq1_decode");
    cyc(1, 1, 1, e_beq(1), "beq_taken");
    cyc(1, 1, 0, e_fetch(1), "beq0_fetch");
    cyc(1, 1, 0, e_decode(0), "beq0_decode");
    cyc(1, 1, 0, e_beq(0), "beq_not_taken");
    instr(7'b1101111, 3'b000, 1'b0);
    cyc(1, 1, 0, e_fetch(1), "jal_fetch");
    cyc(1, 1, 0, e_decode(0), "jal_decode");
    cyc(1, 1, 0, e_jal(), "jal_exec");
    cyc(1, 1, 0, e_aluwb(), "jal_wb");
    instr(7'b0000000, 3'b000, 1'b0);
    cyc(1, 1, 0, e_fetch(1), "ill_fetch");
    cyc(1, 1, 0, e_decode(1), "ill_decode");
    instr(7'b0000011, 3'b000, 1'b0);
    cyc(1, 0, 0, e_fetch(0), "ill_then_fetch_stall");
    cyc(1, 1, 0, e_fetch(1), "ldst_fetch");
    cyc(1, 1, 0, e_decode(0), "ldst_decode");
    cyc(1, 1, 0, e_memadr(0), "ldst_memadr");
    cyc(1, 0, 0, e_memread(), "ldst_memread_wait");
    cyc(1, 1, 0, e_memread(), "ldst_memread");
    cyc(1, 1, 0, e_memwb(), "ldst_memwb");
    cyc(1, 1, 0, e_fetch(1), "rst_fetch");
    cyc(1, 1, 0, e_decode(0), "rst_decode");
    cyc(1, 1, 0, e_memadr(0), "rst_memadr");
    cyc(0, 1, 0, e_rst(), "rst_mid_memread");
    cyc(0, 1, 0, e_rst(), "rst_held");
    instr(7'b0110011, 3'b000, 1'b1);
    cyc(1, 1, 0, e_fetch(1), "post_rst_fetch");
    cyc(1, 1, 0, e_decode(0), "post_rst_decode");
    cyc(1, 1, 0, e_execr(3'b001), "post_rst_exec");
    cyc(1, 1, 0, e_aluwb(), "post_rst_wb");
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL provide these ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- op_6_0  in  7  opcode of the latched instruction register.
- funct3  in  3  instr[14:12].
- funct7_5  in  1  instr[30].
- zero_flag  in  1  ALU zero result, same cycle.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  PC register load enable.
- adr_src  out  1  memory address: 0 = PC, 1 = ALU result register.
- mem_req  out  1  memory access request.
- mem_write  out  1  memory write strobe; qualified by mem_req.
- ir_write  out  1  instruction register and old-PC register load enable.
- result_src  out  2  00 = ALU-out register, 01 = data register, 10 = ALU result.
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1 register.
- alu_src_b  out  2  00 = rs2 register, 01 = immediate, 10 = constant 4.
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- reg_write  out  1  register file write enable.
- alu_control  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- illegal_instr  out  1  one-cycle pulse: unsupported opcode.
- instr_done  out  1  one-cycle pulse: instruction retired.

Function
REQ-003 The FSM states SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ and JAL.
REQ-004 Outputs SHALL be decoded combinationally from the state register and the inputs. Every output not listed for a state SHALL be 0.
REQ-005 FETCH:
- Asserts mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_control=000, result_src=10.
- When mem_ready=1, also asserts ir_write=1 and pc_write=1, then goes to DECODE.
- When mem_ready=0, holds in FETCH with ir_write=0 and pc_write=0.
REQ-006 DECODE:
- Asserts alu_src_a=01, alu_src_b=01, imm_src=10, alu_control=000 (branch target precompute).
- Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL.
- Any other opcode -> FETCH with illegal_instr=1 for that cycle.
REQ-007 MEMADR:
- Asserts alu_src_a=10, alu_src_b=01, alu_control=000.
- imm_src=00 for a load, 01 for a store.
- Next state: load -> MEMREAD; store -> MEMWRITE.
REQ-008 MEMREAD:
- Asserts mem_req=1, adr_src=1, result_src=00.
- Goes to MEMWB when mem_ready=1; otherwise holds.
REQ-009 MEMWB SHALL assert result_src=01, reg_write=1 and instr_done=1, then go to FETCH.
REQ-010 MEMWRITE:
- Asserts mem_req=1, mem_write=1, adr_src=1, result_src=00.
- When mem_ready=1, asserts instr_done=1 and goes to FETCH; otherwise holds with mem_write still asserted.
REQ-011 EXECUTER SHALL assert alu_src_a=10 and alu_src_b=00, then go to ALUWB.
REQ-012 EXECUTEI SHALL assert alu_src_a=10, alu_src_b=01 and imm_src=00, then go to ALUWB.
REQ-013 ALU decoding in EXECUTER and EXECUTEI SHALL map funct3 as follows:
- 000 -> sub when op_6_0[5]=1 and funct7_5=1; otherwise add.
- 010 -> slt; 110 -> or; 111 -> and.
- Any other funct3 -> add.
REQ-014 ALUWB SHALL assert result_src=00, reg_write=1 and instr_done=1, then go to FETCH.
REQ-015 BEQ:
- Asserts alu_src_a=10, alu_src_b=00, alu_control=001, result_src=00.
- Asserts pc_write=zero_flag and instr_done=1, then goes to FETCH.
REQ-016 JAL:
- Asserts alu_src_a=01, alu_src_b=10, alu_control=000, result_src=00, pc_write=1.
- Then goes to ALUWB; the link write and instr_done occur in ALUWB.
REQ-017 Cycle counts with mem_ready tied to 1 SHALL be:
- load: 5; store: 4; R-type and I-type ALU: 4; beq: 3; jal: 4; illegal opcode: 2 (FETCH, DECODE).
REQ-018 Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE SHALL add exactly one cycle; no other state SHALL wait.
REQ-019 mem_write SHALL never be asserted outside MEMWRITE, and reg_write SHALL never be asserted outside MEMWB and ALUWB.

Reset
REQ-020 While rst_n=0, the state SHALL be FETCH, and the state SHALL change immediately on assertion, independent of clk.
REQ-021 Reset asserted mid-instruction SHALL abandon that instruction with no further reg_write, mem_write or pc_write.
REQ-022 Once rst_n rises, the first clk edge SHALL evaluate FETCH.
REQ-023 Because FETCH drives mem_req=1 combinationally, mem_req SHALL read 1 during reset; all other strobes SHALL read 0.

Verification
REQ-024 Load: op 0000011, mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 with result_src=01 in cycle 5 only; instr_done in cycle 5.
REQ-025 Store with stall: op 0100011, mem_ready=0 for 2 cycles in MEMWRITE -> mem_write=1 for 3 consecutive cycles, instr_done on cycle 6, reg_write=0 throughout.
REQ-026 R-type sub: op 0110011, funct3=000, funct7_5=1 -> alu_control=001 in EXECUTER; with funct7_5=0 -> 000; reg_write=1 in cycle 4.
REQ-027 BEQ: zero_flag=1 -> pc_write=1 in cycle 3; zero_flag=0 -> pc_write=0 in cycle 3; both cases return to FETCH.
REQ-028 Illegal opcode 0000000 -> illegal_instr=1 in cycle 2, FETCH in cycle 3, no reg_write or mem_write.
REQ-029 Reset mid-MEMREAD: drop rst_n between clk edges -> state is FETCH before the next edge and mem_write=0; after release, a fetch completes normally.
